usb_tx_encoder: RTL and testbench

- Full-speed USB serial transmit path, on the opposite end of the bus from the receiver's EOP detector.
- Accepts packet bytes over a valid/ready handshake and prepends the SYNC pattern.
- Bit-stuffs, NRZI-encodes and drives d_plus/d_minus, then terminates each packet with a standard EOP (SE0, SE0, J).
- Sits between the packet/CRC formatter and the bus drivers.

---
 rtl/usb_tx_encoder_if.sv | 10 +
 rtl/usb_tx_encoder.sv | 174 +++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_encoder_if.sv
// Byte-stream handshake between the packet/CRC formatter and the USB transmit encoder.
interface usb_tx_encoder_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
    modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmit path: SYNC prefix, bit stuffing, NRZI line coding and EOP.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    usb_tx_encoder_if.slave tx,
    output logic            d_plus,
    output logic            d_minus,
    output logic            tx_busy,
    output logic            tx_done,
    output logic            tx_error
);
    localparam int            TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP1,
        S_EOP2,
        S_EOPJ
    } state_t;

    state_t        state_q, state_nx;
    logic [TW-1:0] timer_q, timer_nx;
    logic [2:0]    bit_idx_q, bit_idx_nx, idx_inc;
    logic [2:0]    ones_q, ones_nx;
    logic          line_j_q, line_j_nx;
    logic          hold_full_q, hold_last_q, cur_last_q;
    logic [7:0]    hold_data_q, cur_byte_q;
    logic          accept, load, sym_edge;
    logic          emit, emit_bit, stuff, toggle;
    logic          err_nx, done_nx, dp_nx, dm_nx;

    assign accept      = tx.tx_valid && !hold_full_q;
    assign tx.tx_ready = !hold_full_q;
    assign tx_busy     = (state_q != S_IDLE);
    assign sym_edge    = (state_q != S_IDLE) && (timer_q == T_LAST);
    assign idx_inc     = bit_idx_q + 3'd1;
    assign timer_nx    = ((state_q == S_IDLE) || (timer_q == T_LAST)) ? '0 : timer_q + TW'(1);

    always_comb begin
        state_nx   = state_q;
        bit_idx_nx = bit_idx_q;
        ones_nx    = ones_q;
        line_j_nx  = line_j_q;
        load       = 1'b0;
        emit       = 1'b0;
        emit_bit   = 1'b0;
        stuff      = 1'b0;
        err_nx     = 1'b0;
        done_nx    = 1'b0;
        dp_nx      = 1'b1;
        dm_nx      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A full holding register is what kicks off a packet, so a byte
                // parked during EOP starts the next SYNC right after IDLE.
                if (hold_full_q) begin
                    state_nx   = S_SYNC;
                    bit_idx_nx = 3'd0;
                    emit       = 1'b1;
                    emit_bit   = 1'b0;
                end
            end
            S_SYNC, S_DATA: begin
                if (sym_edge) begin
                    if (ones_q == 3'd6) begin
                        stuff = 1'b1;
                    end else if (bit_idx_q != 3'd7) begin
                        bit_idx_nx = idx_inc;
                        emit       = 1'b1;
                        emit_bit   = (state_q == S_SYNC) ? (idx_inc == 3'd7) : cur_byte_q[idx_inc];
                    end else if ((state_q == S_DATA) && cur_last_q) begin
                        state_nx = S_EOP1;
                    end else if (hold_full_q) begin
                        state_nx   = S_DATA;
                        load       = 1'b1;
                        bit_idx_nx = 3'd0;
                        emit       = 1'b1;
                        emit_bit   = hold_data_q[0];
                    end else begin
                        state_nx = S_EOP1;
                        err_nx   = 1'b1;
                    end
                end
            end
            S_EOP1: begin
                if (sym_edge) state_nx = S_EOP2;
            end
            S_EOP2: begin
                if (sym_edge) begin
                    state_nx  = S_EOPJ;
                    line_j_nx = 1'b1;
                    ones_nx   = 3'd0;
                end
            end
            S_EOPJ: begin
                if (sym_edge) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // NRZI: a zero (data or stuff) flips the line, a one holds it.
        toggle = stuff || (emit && !emit_bit);
        if (toggle) begin
            line_j_nx = !line_j_q;
            ones_nx   = 3'd0;
        end else if (emit) begin
            ones_nx = ones_q + 3'd1;
        end

        case (state_nx)
            S_EOP1, S_EOP2: begin
                dp_nx = 1'b0;
                dm_nx = 1'b0;
            end
            S_SYNC, S_DATA: begin
                dp_nx = line_j_nx;
                dm_nx = !line_j_nx;
            end
            default: begin
                dp_nx = 1'b1;
                dm_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            ones_q      <= 3'd0;
            line_j_q    <= 1'b1;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            cur_last_q  <= 1'b0;
            d_plus      <= 1'b1;
            d_minus     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            timer_q   <= timer_nx;
            bit_idx_q <= bit_idx_nx;
            ones_q    <= ones_nx;
            line_j_q  <= line_j_nx;
            d_plus    <= dp_nx;
            d_minus   <= dm_nx;
            tx_done   <= done_nx;
            tx_error  <= err_nx;
            if (load) begin
                hold_full_q <= 1'b0;
            end else if (accept) begin
                hold_full_q <= 1'b1;
            end
            if (accept) hold_last_q <= tx.tx_last;
            if (load) cur_last_q <= hold_last_q;
        end
    end

    // Byte payloads carry no reset; hold_full/cur_last gate every use of them.
    always_ff @(posedge clk) begin
        if (accept) hold_data_q <= tx.tx_data;
        if (load) cur_byte_q <= hold_data_q;
    end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Randomised and directed bench for usb_tx_encoder against a symbol-level packet model.
module tb_usb_tx_encoder;
    localparam int         CLKS = 8;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LS   = 2'b00;
    localparam logic [15:0] SYNC_SYMS = {LK, LJ, LK, LJ, LK, LJ, LK, LK};

    logic clk = 1'b0;
    logic rst;
    logic dp, dm, busy, done, err;

    usb_tx_encoder_if tx_if ();

    usb_tx_encoder #(.CLKS_PER_BIT(CLKS)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx       (tx_if),
        .d_plus   (dp),
        .d_minus  (dm),
        .tx_busy  (busy),
        .tx_done  (done),
        .tx_error (err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] pk_data [8];
    int         pk_n;
    bit         pk_last;
    logic [1:0] m_sym [160];
    int         m_nsym;
    int         m_first [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line symbols of the whole packet: SYNC + bytes LSB first, stuffed, NRZI, then EOP.
    task automatic build_model();
        logic [1:0] lvl;
        int         ones;
        logic       b;
        lvl    = LJ;
        ones   = 0;
        m_nsym = 0;
        for (int i = 0; i < 8 + 8 * pk_n; i++) begin
            if (i >= 8 && (i % 8) == 0) m_first[i / 8 - 1] = m_nsym;
            if (i < 8) b = (i == 7);
            else       b = pk_data[i / 8 - 1][i % 8];
            if (!b) lvl = (lvl == LJ) ? LK : LJ;
            m_sym[m_nsym] = lvl;
            m_nsym++;
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = (lvl == LJ) ? LK : LJ;
                m_sym[m_nsym] = lvl;
                m_nsym++;
                ones = 0;
            end
        end
        m_sym[m_nsym] = LS; m_nsym++;
        m_sym[m_nsym] = LS; m_nsym++;
        m_sym[m_nsym] = LJ; m_nsym++;
    endtask

    task automatic pin_model(input string name, input logic [7:0] byte_v, input int exp_n,
                             input logic [39:0] exp_pk);
        pk_data[0] = byte_v;
        pk_n       = 1;
        pk_last    = 1'b1;
        build_model();
        chk({name, "_nsym"}, 32'(m_nsym), 32'(exp_n));
        chk({name, "_first"}, 32'(m_first[0]), 32'd8);
        for (int i = 0; i < exp_n; i++)
            chk($sformatf("%s_sym%0d", name, i), 32'(m_sym[i]), 32'(exp_pk[39 - 2 * i -: 2]));
    endtask

    task automatic run_packet(input string name, input int abort_after_load);
        int         a [8];
        int         l [8];
        int         total, abort_at, k, c;
        logic [1:0] ln;
        logic       rdy, busy_e, done_e, err_e;
        build_model();
        for (int j = 0; j < pk_n; j++) l[j] = 1 + CLKS * m_first[j];
        a[0] = 0;
        for (int j = 1; j < pk_n; j++) a[j] = l[j - 1] + 1;
        total    = m_nsym * CLKS + 1;
        abort_at = (abort_after_load >= 0) ? l[0] + abort_after_load : -1;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = pk_data[0];
        tx_if.tx_last  = pk_last && (pk_n == 1);
        for (int r = 0; r <= total + 2; r++) begin
            @(posedge clk);
            #1;
            if (r == abort_at) begin
                #2 rst = 1'b1;
                #1 chk({name, "_reset_mid"}, 32'({dp, dm, busy, tx_if.tx_ready, done, err}),
                       32'(6'b10_0100));
                tx_if.tx_valid = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            k = -1;
            for (int j = pk_n - 1; j >= 0; j--) if (a[j] > r) k = j;
            if (k >= 0) begin
                tx_if.tx_valid = 1'b1;
                tx_if.tx_data  = pk_data[k];
                tx_if.tx_last  = pk_last && (k == pk_n - 1);
            end else begin
                tx_if.tx_valid = 1'b0;
            end
            ln = LJ; rdy = 1'b1; busy_e = 1'b0; done_e = 1'b0; err_e = 1'b0;
            if (r >= 1 && r < total) begin
                c      = r - 1;
                ln     = m_sym[c / CLKS];
                busy_e = 1'b1;
                err_e  = !pk_last && (c == (m_nsym - 3) * CLKS);
            end
            if (r == total) done_e = 1'b1;
            for (int j = 0; j < pk_n; j++) if (r >= a[j] && r < l[j]) rdy = 1'b0;
            chk($sformatf("%s_r%0d", name, r), 32'({dp, dm, busy, tx_if.tx_ready, done, err}),
                32'({ln, busy_e, rdy, done_e, err_e}));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_last  = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 chk("reset_state", 32'({dp, dm, busy, tx_if.tx_ready, done, err}), 32'(6'b10_0100));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("idle_after_reset", 32'({dp, dm, busy, tx_if.tx_ready, done, err}), 32'(6'b10_0100));

        pin_model("pin00", 8'h00, 19, {SYNC_SYMS, LJ, LK, LJ, LK, LJ, LK, LJ, LK, LS, LS, LJ, 2'b00});
        pin_model("pinFF", 8'hFF, 20, {SYNC_SYMS, LK, LK, LK, LK, LK, LJ, LJ, LJ, LJ, LS, LS, LJ});
        pin_model("pinFC", 8'hFC, 20, {SYNC_SYMS, LJ, LK, LK, LK, LK, LK, LK, LK, LJ, LS, LS, LJ});

        pk_n = 1; pk_last = 1'b1;
        pk_data[0] = 8'h00; run_packet("b00", -1);
        pk_data[0] = 8'hFF; run_packet("bFF", -1);
        pk_data[0] = 8'h3F; run_packet("b3F", -1);
        pk_data[0] = 8'hFC; run_packet("bFC", -1);
        pk_n = 2; pk_data[0] = 8'hA5; pk_data[1] = 8'h5A;
        run_packet("b2b", -1);
        pk_n = 1; pk_last = 1'b0; pk_data[0] = 8'h01;
        run_packet("underrun", -1);
        pk_n = 2; pk_last = 1'b1; pk_data[0] = 8'hA5; pk_data[1] = 8'h5A;
        run_packet("abort", 5);
        pk_n = 1; pk_data[0] = 8'h00;
        run_packet("after_reset", -1);

        for (int p = 0; p < 12; p++) begin
            nb      = int'($urandom_range(1, 4));
            pk_n    = nb;
            pk_last = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < nb; j++) begin
                case ($urandom_range(0, 3))
                    0:       pk_data[j] = 8'hFF;
                    1:       pk_data[j] = 8'(($urandom_range(0, 255)) | 8'hF8);
                    default: pk_data[j] = 8'($urandom_range(0, 255));
                endcase
            end
            run_packet($sformatf("rand%0d", p), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
